// File: rtl/pipeline_ex_mem_wb.sv
// Back half of the 5-stage MIPS datapath: EX, MEM and WB stages with the
// EX/MEM and MEM/WB registers and a word-addressed data memory.
module pipeline_ex_mem_wb #(
    parameter int DMEM_DEPTH = 64,
    parameter int DMEM_AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  control_bits_in,
    input  logic [31:0] ID_EX_NPC,
    input  logic [31:0] ID_EX_A,
    input  logic [31:0] ID_EX_B,
    input  logic [31:0] signExtended,
    input  logic [4:0]  EX_Mux_0,
    input  logic [4:0]  EX_Mux_1,
    output logic        PCSrc,
    output logic [31:0] EX_MEM_NPC,
    output logic        RegWrite,
    output logic [4:0]  MEM_WB_Writereg,
    output logic [31:0] MEM_WB_Writedata
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_t;

    function automatic alu_op_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_op_t op;
        op = ALU_ADD;
        case (alu_op)
            2'b01: op = ALU_SUB;
            2'b10: begin
                case (funct)
                    6'b100010: op = ALU_SUB;
                    6'b100100: op = ALU_AND;
                    6'b100101: op = ALU_OR;
                    6'b100111: op = ALU_NOR;
                    6'b101010: op = ALU_SLT;
                    default:   op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Add/sub wrap silently; slt compares as two's complement.
    function automatic logic [31:0] alu_exec(input alu_op_t op,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
        logic [31:0] res;
        case (op)
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_NOR: res = ~(a | b);
            ALU_SLT: res = (a < b) ? 32'd1 : 32'd0;
            default: res = a + b;
        endcase
        return res;
    endfunction

    // ---------------- EX stage (combinational from ID/EX inputs) ----------------
    logic               reg_write_p0, mem_to_reg_p0, branch_p0, mem_write_p0;
    logic               reg_dst_p0, alu_src_p0;
    logic [1:0]         alu_op_p0;
    logic signed [31:0] alu_a_p0, alu_b_p0;
    logic [31:0]        alu_res_p0, target_p0;
    logic [4:0]         dest_p0;
    logic               zero_p0;
    logic               unused_mem_read;

    assign reg_write_p0  = control_bits_in[8];
    assign mem_to_reg_p0 = control_bits_in[7];
    assign branch_p0     = control_bits_in[6];
    assign mem_write_p0  = control_bits_in[4];
    assign reg_dst_p0    = control_bits_in[3];
    assign alu_op_p0     = control_bits_in[2:1];
    assign alu_src_p0    = control_bits_in[0];
    // MemRead has no effect: the memory read port is always live.
    assign unused_mem_read = control_bits_in[5];

    assign alu_a_p0   = ID_EX_A;
    assign alu_b_p0   = alu_src_p0 ? signExtended : ID_EX_B;
    assign alu_res_p0 = alu_exec(alu_decode(alu_op_p0, signExtended[5:0]), alu_a_p0, alu_b_p0);
    assign zero_p0    = (alu_res_p0 == 32'd0);
    assign dest_p0    = reg_dst_p0 ? EX_Mux_1 : EX_Mux_0;
    assign target_p0  = ID_EX_NPC + {signExtended[29:0], 2'b00};

    // ---------------- EX/MEM register ----------------
    logic        reg_write_p1, mem_to_reg_p1, branch_p1, mem_write_p1, zero_p1;
    logic [31:0] target_p1, alu_res_p1, store_p1;
    logic [4:0]  dest_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            branch_p1     <= 1'b0;
            mem_write_p1  <= 1'b0;
            zero_p1       <= 1'b0;
            target_p1     <= 32'd0;
            alu_res_p1    <= 32'd0;
            store_p1      <= 32'd0;
            dest_p1       <= 5'd0;
        end else begin
            reg_write_p1  <= reg_write_p0;
            mem_to_reg_p1 <= mem_to_reg_p0;
            branch_p1     <= branch_p0;
            mem_write_p1  <= mem_write_p0;
            zero_p1       <= zero_p0;
            target_p1     <= target_p0;
            alu_res_p1    <= alu_res_p0;
            store_p1      <= ID_EX_B;
            dest_p1       <= dest_p0;
        end
    end

    assign PCSrc      = branch_p1 & zero_p1;
    assign EX_MEM_NPC = target_p1;

    // ---------------- MEM stage: data memory ----------------
    logic [31:0]        dmem [DMEM_DEPTH];
    logic [DMEM_AW-1:0] mem_addr_p1;
    logic [31:0]        rd_data_p1;

    // Byte-offset bits and bits above the word index are dropped, so
    // addresses wrap modulo the memory depth.
    assign mem_addr_p1 = alu_res_p1[DMEM_AW+1:2];
    assign rd_data_p1  = dmem[mem_addr_p1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= 32'd0;
            end
        end else if (mem_write_p1) begin
            dmem[mem_addr_p1] <= store_p1;
        end
    end

    // ---------------- MEM/WB register ----------------
    logic        reg_write_p2, mem_to_reg_p2;
    logic [31:0] rd_data_p2, alu_res_p2;
    logic [4:0]  dest_p2;

    // Captures the pre-write read data when a store hits the same word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
            rd_data_p2    <= 32'd0;
            alu_res_p2    <= 32'd0;
            dest_p2       <= 5'd0;
        end else begin
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
            rd_data_p2    <= rd_data_p1;
            alu_res_p2    <= alu_res_p1;
            dest_p2       <= dest_p1;
        end
    end

    // ---------------- WB stage ----------------
    assign RegWrite         = reg_write_p2;
    assign MEM_WB_Writereg  = dest_p2;
    assign MEM_WB_Writedata = mem_to_reg_p2 ? rd_data_p2 : alu_res_p2;

endmodule

// File: tb/tb_pipeline_ex_mem_wb.sv
// Randomised bench for pipeline_ex_mem_wb against an in-order instruction
// interpreter: each instruction executes fully before the next one.
module tb_pipeline_ex_mem_wb;

    localparam int DMEM_DEPTH = 64;
    localparam int DMEM_AW    = 6;

    logic        clk;
    logic        reset;
    logic [8:0]  control_bits_in;
    logic [31:0] ID_EX_NPC, ID_EX_A, ID_EX_B, signExtended;
    logic [4:0]  EX_Mux_0, EX_Mux_1;
    logic        PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic        RegWrite;
    logic [4:0]  MEM_WB_Writereg;
    logic [31:0] MEM_WB_Writedata;

    pipeline_ex_mem_wb #(
        .DMEM_DEPTH(DMEM_DEPTH),
        .DMEM_AW   (DMEM_AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .control_bits_in (control_bits_in),
        .ID_EX_NPC       (ID_EX_NPC),
        .ID_EX_A         (ID_EX_A),
        .ID_EX_B         (ID_EX_B),
        .signExtended    (signExtended),
        .EX_Mux_0        (EX_Mux_0),
        .EX_Mux_1        (EX_Mux_1),
        .PCSrc           (PCSrc),
        .EX_MEM_NPC      (EX_MEM_NPC),
        .RegWrite        (RegWrite),
        .MEM_WB_Writereg (MEM_WB_Writereg),
        .MEM_WB_Writedata(MEM_WB_Writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pcsrc;
        logic [31:0] npc;
        logic        regwrite;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl_mem [DMEM_DEPTH];
    exp_t        prev;

    localparam logic [8:0] C_RTYPE = 9'b1_0_000_1100;
    localparam logic [8:0] C_SW    = 9'b0_0_001_0001;
    localparam logic [8:0] C_LW    = 9'b1_1_010_0001;
    localparam logic [8:0] C_BEQ   = 9'b0_0_100_0010;
    localparam logic [8:0] C_BUB   = 9'b0_0_000_0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.pcsrc = 1'b0; e.npc = 32'd0; e.regwrite = 1'b0; e.wreg = 5'd0; e.wdata = 32'd0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DMEM_DEPTH; i++) mdl_mem[i] = 32'd0;
        prev = zero_exp();
    endtask

    // Executes one instruction in program order against the model memory.
    task automatic model_exec(input logic [8:0] c, input logic [31:0] npc, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm,
                              input logic [4:0] rt, input logic [4:0] rd, output exp_t e);
        logic [31:0] opb, res, rdata;
        int          idx;
        opb = c[0] ? imm : b;
        case (c[2:1])
            2'b01: res = a - opb;
            2'b10: begin
                case (imm[5:0])
                    6'd34:   res = a - opb;
                    6'd36:   res = a & opb;
                    6'd37:   res = a | opb;
                    6'd39:   res = ~(a | opb);
                    6'd42:   res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    default: res = a + opb;
                endcase
            end
            default: res = a + opb;
        endcase
        idx        = int'((res / 4) % DMEM_DEPTH);
        rdata      = mdl_mem[idx];
        e.pcsrc    = c[6] && (res == 32'd0);
        e.npc      = npc + imm * 4;
        e.regwrite = c[8];
        e.wreg     = c[3] ? rd : rt;
        e.wdata    = c[7] ? rdata : res;
        if (c[4]) mdl_mem[idx] = b;
    endtask

    // Applies one instruction; after the edge the branch outputs belong to
    // it and the writeback outputs to the instruction issued before it.
    task automatic issue(input logic [8:0] c, input logic [31:0] npc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rt, input logic [4:0] rd);
        exp_t e;
        @(negedge clk);
        control_bits_in = c; ID_EX_NPC = npc; ID_EX_A = a; ID_EX_B = b;
        signExtended = imm; EX_Mux_0 = rt; EX_Mux_1 = rd;
        model_exec(c, npc, a, b, imm, rt, rd, e);
        @(posedge clk);
        #1;
        chk("pcsrc",    32'(PCSrc),           32'(e.pcsrc));
        chk("ex_npc",   EX_MEM_NPC,           e.npc);
        chk("regwrite", 32'(RegWrite),        32'(prev.regwrite));
        chk("writereg", 32'(MEM_WB_Writereg), 32'(prev.wreg));
        chk("writedata", MEM_WB_Writedata,    prev.wdata);
        prev = e;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_pcsrc"},  32'(PCSrc),           32'd0);
        chk({tag, "_npc"},    EX_MEM_NPC,           32'd0);
        chk({tag, "_rw"},     32'(RegWrite),        32'd0);
        chk({tag, "_wreg"},   32'(MEM_WB_Writereg), 32'd0);
        chk({tag, "_wdata"},  MEM_WB_Writedata,     32'd0);
    endtask

    task automatic drive_idle();
        control_bits_in = 9'd0; ID_EX_NPC = 32'd0; ID_EX_A = 32'd0; ID_EX_B = 32'd0;
        signExtended = 32'd0; EX_Mux_0 = 5'd0; EX_Mux_1 = 5'd0;
    endtask

    initial begin
        logic [8:0]  rc;
        logic [15:0] imm16;
        logic [31:0] ra, rimm;
        logic [5:0]  functs [6];
        functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};

        drive_idle();
        reset = 1'b0;
        model_reset();
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // R-type add, then a bubble to expose its writeback
        issue(C_RTYPE, 32'h0, 32'd5, 32'd7, 32'h20, 5'd0, 5'd3);
        issue(C_BUB, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("add_rw",    32'(RegWrite),        32'd1);
        chk("add_wreg",  32'(MEM_WB_Writereg), 32'd3);
        chk("add_wdata", MEM_WB_Writedata,     32'd12);

        // sw then lw back-to-back on word 3
        issue(C_SW, 32'h0, 32'd8, 32'hDEADBEEF, 32'd4, 5'd0, 5'd0);
        issue(C_LW, 32'h0, 32'd8, 32'd0, 32'd4, 5'd9, 5'd0);
        issue(C_BUB, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("lw_wdata", MEM_WB_Writedata,     32'hDEADBEEF);
        chk("lw_wreg",  32'(MEM_WB_Writereg), 32'd9);

        // beq taken / not taken
        issue(C_BEQ, 32'h100, 32'h10, 32'h10, 32'd3, 5'd0, 5'd0);
        chk("beq_t_pcsrc", 32'(PCSrc), 32'd1);
        chk("beq_t_npc",   EX_MEM_NPC, 32'h10C);
        issue(C_BEQ, 32'h100, 32'd1, 32'd2, 32'd3, 5'd0, 5'd0);
        chk("beq_n_pcsrc", 32'(PCSrc), 32'd0);
        chk("beq_n_npc",   EX_MEM_NPC, 32'h10C);

        // signed slt
        issue(C_RTYPE, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd42, 5'd0, 5'd4);
        issue(C_BUB, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("slt_wdata", MEM_WB_Writedata, 32'd1);

        // address wrap: word 64 aliases word 0
        issue(C_SW, 32'h0, 32'h100, 32'hCAFEF00D, 32'd0, 5'd0, 5'd0);
        issue(C_LW, 32'h0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
        issue(C_BUB, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("wrap_wdata", MEM_WB_Writedata, 32'hCAFEF00D);

        // reset mid-stream with an R-type and a store in flight
        issue(C_RTYPE, 32'h0, 32'd9, 32'd1, 32'h20, 5'd0, 5'd5);
        issue(C_SW, 32'h40, 32'd20, 32'h12345678, 32'd0, 5'd0, 5'd0);
        #3;
        reset = 1'b0;
        drive_idle();
        #1;
        check_outputs_zero("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(C_LW, 32'h0, 32'd20, 32'd0, 32'd0, 5'd6, 5'd0);
        issue(C_BUB, 32'h0, 32'd0, 32'd0, 32'd0, 5'd2, 5'd0);
        chk("rst_lw_wdata", MEM_WB_Writedata, 32'd0);
        issue(C_BUB, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("rst_bub_rw", 32'(RegWrite), 32'd0);

        // randomised instruction stream
        for (int n = 0; n < 400; n++) begin
            rc    = 9'($urandom);
            imm16 = 16'($urandom);
            if (rc[2:1] == 2'b10 && $urandom_range(0, 3) != 0)
                imm16[5:0] = functs[$urandom_range(0, 5)];
            rimm = {{16{imm16[15]}}, imm16};
            ra   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 511)) : $urandom;
            issue(rc, $urandom, ra, ($urandom_range(0, 3) == 0) ? ra : $urandom, rimm,
                  5'($urandom), 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ex_mem_wb.md
Name: pipeline_ex_mem_wb

Overview:
Back half of the 5-stage MIPS datapath: the EX, MEM and WB stages with the EX/MEM and MEM/WB pipeline registers and data memory. It consumes the ID/EX-side bundle produced by the fetch/decode half. It returns the feedback that half needs: the branch decision and target (PCSrc, EX_MEM_NPC) and the register-file write port (RegWrite, MEM_WB_Writereg, MEM_WB_Writedata). There is no forwarding, hazard detection or flush logic.

Parameters:
DMEM_DEPTH, 64, data memory size in 32-bit words (power of 2).
DMEM_AW, 6, log2(DMEM_DEPTH); word-index width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
control_bits_in  in  9  [8]RegWrite [7]MemtoReg [6]Branch [5]MemRead [4]MemWrite [3]RegDst [2:1]ALUOp [0]ALUSrc
ID_EX_NPC  in  32  PC+4 of the instruction in EX
ID_EX_A  in  32  rs read data
ID_EX_B  in  32  rt read data; also store data
signExtended  in  32  sign-extended immediate; [5:0] is funct
EX_Mux_0  in  5  rt field
EX_Mux_1  in  5  rd field
PCSrc  out  1  branch taken = EX/MEM Branch & EX/MEM Zero
EX_MEM_NPC  out  32  registered branch target
RegWrite  out  1  MEM/WB RegWrite
MEM_WB_Writereg  out  5  registered destination register
MEM_WB_Writedata  out  32  writeback value

Behaviour:
- EX stage (combinational, from inputs):
  - ALU operand B = ALUSrc ? signExtended : ID_EX_B.
  - Destination = RegDst ? EX_Mux_1 : EX_Mux_0.
  - Target = ID_EX_NPC + (signExtended << 2), mod 2^32.
- ALU control:
  - ALUOp 00 -> add; 01 -> sub; 11 -> add.
  - ALUOp 10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt; any other funct -> add.
- ALU arithmetic: add/sub wrap mod 2^32 with no overflow trap. slt is signed and yields 32'd1 or 32'd0. Zero = (result == 0).
- EX/MEM register, loaded every rising edge: WB bits, M bits, target, Zero, ALU result, store data (ID_EX_B), destination.
- PCSrc = EX/MEM Branch & EX/MEM Zero. PCSrc and EX_MEM_NPC are valid the cycle after the instruction was in EX.
- Data memory, word-indexed by ALU result[DMEM_AW+1:2]:
  - Address bits [1:0] are ignored; higher bits are ignored, so addresses wrap mod DMEM_DEPTH.
  - Read is combinational.
  - Write is synchronous on the rising edge when EX/MEM MemWrite = 1.
  - MemRead gates nothing; read data is always available.
- MEM/WB register, loaded every rising edge: RegWrite, MemtoReg, read data, ALU result, destination.
- WB (combinational): MEM_WB_Writedata = MemtoReg ? read data : ALU result. RegWrite and MEM_WB_Writereg come straight from MEM/WB.
- Latency: an instruction present on the inputs in cycle N appears on the writeback outputs in cycle N+2.
- Read-during-write to the same word on one edge: MEM/WB captures the old data; the new data is visible from the next cycle.
- Reset (asynchronous, any time, including mid-operation):
  - All EX/MEM and MEM/WB fields and all memory words clear to 0.
  - Outputs during reset: PCSrc=0, EX_MEM_NPC=0, RegWrite=0, MEM_WB_Writereg=0, MEM_WB_Writedata=0.
  - In-flight stores are lost.
  - After reset release, the first rising edge loads normally.
- A bubble is all-zero control_bits_in. It flows through with no write, no branch and no register write.

Test Plan:
- R-type add: A=5, B=7, ctrl=9'b1_0_000_1100 (RegWrite, RegDst, ALUOp=10), funct 100000, rd=3 -> two edges later RegWrite=1, Writereg=3, Writedata=12.
- sw then lw:
  - sw: A=8, imm=4, B=0xDEADBEEF, ctrl=9'b0_0_001_0001 -> word index 3 written.
  - Next cycle lw: A=8, imm=4, rt=9, ctrl=9'b1_1_010_0001 -> Writedata=0xDEADBEEF, Writereg=9.
- beq taken: A=B=0x10, NPC=0x100, imm=3, ctrl=9'b0_0_100_0010 -> next cycle PCSrc=1, EX_MEM_NPC=0x10C.
- beq not taken: A=1, B=2 -> PCSrc=0, EX_MEM_NPC=0x10C.
- slt signed: A=0xFFFFFFFF, B=1, funct 101010 -> Writedata=1.
- Address wrap: sw to address 0x100 with DMEM_DEPTH=64 -> lw from address 0 returns the stored value.
- Reset mid-stream: assert reset=0 between edges while a store and an R-type are in flight -> all outputs 0 immediately. After release, lw from that address returns 0 and a bubble yields RegWrite=0.
